// File: rtl/seg7_bin_decoder.sv
// seg7_bin_decoder: samples an active-low seven-segment bus, waits for the pattern to
// settle, decodes it to a hex digit and offers the result as a valid/ready event.
module seg7_bin_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       CLOCK1_50,
  input  logic       RESET_N,
  input  logic [7:0] seg_n,
  input  logic       clr,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_digit,
  output logic       out_blank,
  output logic       out_dp,
  output logic       err_sticky,
  output logic       overrun,
  output logic [7:0] evt_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);

  // Returns {legal, digit} for an active-high {g..a} pattern; all-off is a legal blank.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    case (pat)
      7'h3F:   decode_seg = {1'b1, 4'h0};
      7'h06:   decode_seg = {1'b1, 4'h1};
      7'h5B:   decode_seg = {1'b1, 4'h2};
      7'h4F:   decode_seg = {1'b1, 4'h3};
      7'h66:   decode_seg = {1'b1, 4'h4};
      7'h6D:   decode_seg = {1'b1, 4'h5};
      7'h7D:   decode_seg = {1'b1, 4'h6};
      7'h07:   decode_seg = {1'b1, 4'h7};
      7'h7F:   decode_seg = {1'b1, 4'h8};
      7'h6F:   decode_seg = {1'b1, 4'h9};
      7'h77:   decode_seg = {1'b1, 4'hA};
      7'h7C:   decode_seg = {1'b1, 4'hB};
      7'h39:   decode_seg = {1'b1, 4'hC};
      7'h5E:   decode_seg = {1'b1, 4'hD};
      7'h79:   decode_seg = {1'b1, 4'hE};
      7'h71:   decode_seg = {1'b1, 4'hF};
      7'h00:   decode_seg = {1'b1, 4'h0};
      default: decode_seg = {1'b0, 4'h0};
    endcase
  endfunction

  state_t     r_state;
  logic [7:0] r_samp;
  logic [7:0] r_prev;
  logic [7:0] r_count;
  logic [7:0] r_last;
  logic       r_last_vld;
  logic       r_new_evt;
  logic       r_new_err;
  logic [3:0] r_new_digit;
  logic       r_new_blank;
  logic       r_new_dp;

  logic [6:0] w_pat;
  logic       w_dp;
  logic [4:0] w_dec;
  logic       w_blank;
  logic       w_change;
  logic       w_differs;
  logic       w_xfer;

  // Active-high view of the current sample and handshake qualifiers
  always_comb begin
    w_pat     = ~r_samp[6:0];
    w_dp      = ~r_samp[7];
    w_dec     = decode_seg(w_pat);
    w_blank   = (w_pat == 7'h00);
    w_change  = (r_samp != r_prev);
    w_differs = (!r_last_vld) || (r_last != {w_dp, w_pat});
    w_xfer    = out_valid && out_ready;
  end

  // Input sampling and settle/lock state machine; a lock of a new pattern posts one event
  always_ff @(posedge CLOCK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_IDLE;
      r_samp      <= 8'hFF;
      r_prev      <= 8'hFF;
      r_count     <= 8'd0;
      r_last      <= 8'd0;
      r_last_vld  <= 1'b0;
      r_new_evt   <= 1'b0;
      r_new_err   <= 1'b0;
      r_new_digit <= 4'd0;
      r_new_blank <= 1'b0;
      r_new_dp    <= 1'b0;
    end else begin
      r_samp    <= seg_n;
      r_prev    <= r_samp;
      r_new_evt <= 1'b0;
      r_new_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_SETTLE;
          r_count <= 8'd1;
        end
        ST_SETTLE: begin
          if (w_change) begin
            r_count <= 8'd1;
          end else if (r_count == LP_STABLE) begin
            r_state <= ST_LOCKED;
            if (w_differs) begin
              r_last      <= {w_dp, w_pat};
              r_last_vld  <= 1'b1;
              r_new_evt   <= w_dec[4];
              r_new_err   <= ~w_dec[4];
              r_new_digit <= w_dec[3:0];
              r_new_blank <= w_blank;
              r_new_dp    <= w_dp;
            end
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        ST_LOCKED: begin
          if (w_change) begin
            r_state <= ST_SETTLE;
            r_count <= 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_count <= 8'd0;
        end
      endcase
    end
  end

  // Output event register, sticky flags (a set beats clr) and transfer counter
  always_ff @(posedge CLOCK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      out_valid  <= 1'b0;
      out_digit  <= 4'd0;
      out_blank  <= 1'b0;
      out_dp     <= 1'b0;
      err_sticky <= 1'b0;
      overrun    <= 1'b0;
      evt_count  <= 8'd0;
    end else begin
      if (r_new_evt && (!out_valid || w_xfer)) begin
        out_valid <= 1'b1;
        out_digit <= r_new_digit;
        out_blank <= r_new_blank;
        out_dp    <= r_new_dp;
      end else if (w_xfer) begin
        out_valid <= 1'b0;
      end
      if (w_xfer) begin
        evt_count <= evt_count + 8'd1;
      end
      if (r_new_evt && out_valid && !w_xfer) begin
        overrun <= 1'b1;
      end else if (clr) begin
        overrun <= 1'b0;
      end
      if (r_new_err) begin
        err_sticky <= 1'b1;
      end else if (clr) begin
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_bin_decoder.sv
// Bench for seg7_bin_decoder: directed scenarios plus randomized segment traffic, every
// cycle compared against a run-length/handshake reference model of the decoder.
module tb_seg7_bin_decoder;

  localparam int S = 4;

  logic       CLOCK1_50;
  logic       RESET_N;
  logic [7:0] seg_n;
  logic       clr;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_blank;
  logic       out_dp;
  logic       err_sticky;
  logic       overrun;
  logic [7:0] evt_count;

  int n_chk;
  int n_err;

  logic [6:0] seg_tab [16];

  // reference model state
  logic [7:0] m_prev;
  int         m_run;
  logic       m_p0_vld, m_p1_vld;
  logic [7:0] m_p0_pat, m_p1_pat;
  logic       m_last_vld;
  logic [7:0] m_last;
  logic       m_ov, m_blank, m_dp, m_err, m_ovr;
  logic [3:0] m_dig;
  logic [7:0] m_cnt;

  seg7_bin_decoder #(.STABLE_CYCLES(S)) dut (
    .CLOCK1_50  (CLOCK1_50),
    .RESET_N    (RESET_N),
    .seg_n      (seg_n),
    .clr        (clr),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_digit  (out_digit),
    .out_blank  (out_blank),
    .out_dp     (out_dp),
    .err_sticky (err_sticky),
    .overrun    (overrun),
    .evt_count  (evt_count)
  );

  initial CLOCK1_50 = 1'b0;
  always #5 CLOCK1_50 = ~CLOCK1_50;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {legal, digit} of a raw active-low bus value, found by searching the digit table
  function automatic logic [4:0] ref_decode(input logic [7:0] raw);
    logic [6:0] p;
    p = ~raw[6:0];
    ref_decode = 5'd0;
    if (p == 7'h00) ref_decode = 5'h10;
    for (int i = 0; i < 16; i++) begin
      if (seg_tab[i] == p) ref_decode = {1'b1, 4'(i)};
    end
  endfunction

  task automatic model_reset();
    m_prev = 8'hFF; m_run = 1;
    m_p0_vld = 1'b0; m_p1_vld = 1'b0; m_p0_pat = 8'd0; m_p1_pat = 8'd0;
    m_last_vld = 1'b0; m_last = 8'd0;
    m_ov = 1'b0; m_blank = 1'b0; m_dp = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
    m_dig = 4'd0; m_cnt = 8'd0;
  endtask

  // A value sampled S+1 times in a row is accepted; its outcome is visible two edges later.
  task automatic model_step();
    logic xfer, offer, seterr;
    logic [4:0] dec;
    if (RESET_N !== 1'b1) begin
      model_reset();
    end else begin
      xfer = m_ov && out_ready;
      offer = 1'b0; seterr = 1'b0; dec = 5'd0;
      if (m_p1_vld && (!m_last_vld || m_last != m_p1_pat)) begin
        m_last_vld = 1'b1;
        m_last = m_p1_pat;
        dec = ref_decode(m_p1_pat);
        if (dec[4]) offer = 1'b1;
        else seterr = 1'b1;
      end
      if (xfer) m_cnt = m_cnt + 8'd1;
      if (offer && m_ov && !xfer) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      if (seterr) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
      if (offer && (!m_ov || xfer)) begin
        m_ov = 1'b1;
        m_dig = dec[3:0];
        m_blank = (m_p1_pat[6:0] == 7'h7F);
        m_dp = ~m_p1_pat[7];
      end else if (xfer) begin
        m_ov = 1'b0;
      end
      m_p1_vld = m_p0_vld;
      m_p1_pat = m_p0_pat;
      if (seg_n == m_prev) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_run = 1;
      end
      m_prev = seg_n;
      m_p0_vld = (m_run == S + 1);
      m_p0_pat = seg_n;
    end
  endtask

  task automatic tick();
    @(posedge CLOCK1_50);
    model_step();
    @(negedge CLOCK1_50);
    chk("out_valid", out_valid, m_ov);
    chk("out_digit", out_digit, m_dig);
    chk("out_blank", out_blank, m_blank);
    chk("out_dp", out_dp, m_dp);
    chk("err_sticky", err_sticky, m_err);
    chk("overrun", overrun, m_ovr);
    chk("evt_count", evt_count, m_cnt);
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = -1;
    for (int k = 0; k < bound; k++) begin
      tick();
      if (out_valid === 1'b1) begin
        n = k;
        break;
      end
    end
    if (n < 0) chk("valid_timeout", 8'd0, 8'd1);
  endtask

  task automatic run_events(input int count);
    for (int i = 0; i < count; i++) begin
      seg_n = (i % 2 == 1) ? 8'hC0 : 8'hB0;
      repeat (7) tick();
    end
    repeat (2) tick();
  endtask

  initial begin
    int n;
    logic seen;
    n_chk = 0;
    n_err = 0;
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_reset();
    RESET_N = 1'b0; seg_n = 8'hFF; clr = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_count", evt_count, 8'd0);
    chk("rst_err", err_sticky, 1'b0);
    // digit 3 held with a ready consumer: one event, one handshake
    chk("model_dec_3", {3'd0, ref_decode(8'hB0)}, 8'h13);
    RESET_N = 1'b1; seg_n = 8'hB0; out_ready = 1'b1;
    wait_valid(20, n);
    chk("latency", 8'(n), 8'(S + 2));
    chk("dig3", out_digit, 4'd3);
    chk("dig3_dp", out_dp, 1'b0);
    repeat (6) tick();
    chk("dig3_count", evt_count, 8'd1);
    chk("dig3_norepeat", out_valid, 1'b0);
    // toggling faster than the settle window never produces an event
    seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      seg_n = (t % 2 == 0) ? 8'hC0 : 8'hF9;
      repeat (3) begin tick(); seen = seen | out_valid; end
    end
    chk("toggle_noevent", seen, 1'b0);
    // blank, then dp-only blank
    seg_n = 8'hFF;
    wait_valid(20, n);
    chk("blank", out_blank, 1'b1);
    chk("blank_digit", out_digit, 4'd0);
    seg_n = 8'h7F;
    tick();
    wait_valid(20, n);
    chk("dp_blank", out_blank, 1'b1);
    chk("dp_only", out_dp, 1'b1);
    // illegal pattern sets err_sticky and raises nothing; clr drops it
    seg_n = 8'hAA;
    repeat (2) tick();
    seen = 1'b0;
    repeat (12) begin tick(); seen = seen | out_valid; end
    chk("illegal_noevent", seen, 1'b0);
    chk("illegal_err", err_sticky, 1'b1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("err_cleared", err_sticky, 1'b0);
    // stalled consumer: 5 stays pending, 6 is dropped with overrun
    out_ready = 1'b0; seg_n = 8'h92;
    wait_valid(20, n);
    chk("pend5", out_digit, 4'd5);
    seg_n = 8'h82;
    repeat (10) tick();
    chk("pend5_kept", out_digit, 4'd5);
    chk("overrun_set", overrun, 1'b1);
    out_ready = 1'b1;
    tick();
    chk("hs5_count", evt_count, 8'd4);
    tick();
    chk("hs5_only", out_valid, 1'b0);
    // randomized traffic
    for (int sg = 0; sg < 160; sg++) begin
      int kind;
      int idx;
      int hold;
      logic dpb;
      logic [7:0] v;
      kind = $urandom_range(0, 9);
      idx = $urandom_range(0, 15);
      dpb = 1'($urandom_range(0, 1));
      if (kind < 6) v = {~dpb, ~seg_tab[idx]};
      else if (kind == 6) v = 8'hFF;
      else if (kind == 7) v = 8'h7F;
      else v = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 39) == 0) begin
        RESET_N = 1'b0; tick(); tick(); RESET_N = 1'b1;
      end
      seg_n = v;
      hold = $urandom_range(1, 9);
      for (int h = 0; h < hold; h++) begin
        out_ready = ($urandom_range(0, 9) < 7);
        clr = ($urandom_range(0, 19) == 0);
        tick();
      end
      clr = 1'b0;
    end
    // counter to 255, then asynchronous reset with an event pending
    RESET_N = 1'b0; tick(); RESET_N = 1'b1; out_ready = 1'b1;
    run_events(255);
    chk("cnt_255", evt_count, 8'd255);
    out_ready = 1'b0; seg_n = 8'h92;
    wait_valid(20, n);
    chk("pending_before_rst", out_valid, 1'b1);
    #2 RESET_N = 1'b0;
    model_reset();
    #1;
    chk("async_valid", out_valid, 1'b0);
    chk("async_digit", out_digit, 4'd0);
    chk("async_blank", out_blank, 1'b0);
    chk("async_dp", out_dp, 1'b0);
    chk("async_err", err_sticky, 1'b0);
    chk("async_ovr", overrun, 1'b0);
    chk("async_count", evt_count, 8'd0);
    tick();
    RESET_N = 1'b1; out_ready = 1'b1;
    repeat (2) tick();
    chk("no_hs_after_rst", evt_count, 8'd0);
    run_events(255);
    chk("cnt_255_again", evt_count, 8'd255);
    seg_n = 8'hC0;
    repeat (9) tick();
    chk("cnt_wrap", evt_count, 8'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
